// File: rtl/rename_map_table_ckpt.sv
// Register rename map table with RenameWidth-wide lookup/forwarding and a circular buffer of branch checkpoints.
// Optional macro MAP_TABLE_X0_HARDWIRED_EN pins architectural register 0 to physical tag 0.
module rename_map_table_ckpt #(
  parameter int NumArchRegs = 32,
  parameter int NumPhysRegs = 64,
  parameter int RenameWidth = 2,
  parameter int NumCkpts    = 4,
  localparam int AW = $clog2(NumArchRegs),
  localparam int PW = $clog2(NumPhysRegs),
  localparam int CW = $clog2(NumCkpts)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      ready_o,
  input  logic [RenameWidth-1:0]    valid_i,
  input  logic [RenameWidth*AW-1:0] rs1_i,
  input  logic [RenameWidth*AW-1:0] rs2_i,
  input  logic [RenameWidth*AW-1:0] rd_i,
  input  logic [RenameWidth*PW-1:0] phys_rd_i,
  output logic [RenameWidth*PW-1:0] phys_rs1_o,
  output logic [RenameWidth*PW-1:0] phys_rs2_o,
  output logic [RenameWidth*PW-1:0] old_rd_o,
  input  logic                      ckpt_req_i,
  output logic                      ckpt_gnt_o,
  output logic [CW-1:0]             ckpt_id_o,
  output logic                      ckpt_full_o,
  input  logic                      free_i,
  input  logic                      restore_i,
  input  logic [CW-1:0]             restore_id_i
);

`ifdef MAP_TABLE_X0_HARDWIRED_EN
  localparam logic X0Hard = 1'b1;
`else
  localparam logic X0Hard = 1'b0;
`endif

  typedef enum logic [0:0] {StInit = 1'b0, StRun = 1'b1} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   init_cnt;
  logic [CW-1:0]   head, tail, head_n, tail_n, head_f, restore_off;
  logic [CW:0]     count, count_n, count_f;
  logic            full;
  logic            free_ok, restore_ok, rename_en;
  logic [PW-1:0]   map_q [NumArchRegs];
  logic [PW-1:0]   map_d [NumArchRegs];
  logic [PW-1:0]   ckpt_q [NumCkpts][NumArchRegs];

  // Whether a destination register takes part in renaming (x0 excluded when hardwired).
  function automatic logic rd_renamed(input logic [AW-1:0] rd);
    return !(X0Hard && (rd == {AW{1'b0}}));
  endfunction

  // Source lookup for slot k: youngest older same-group writer wins, else the table.
  function automatic logic [PW-1:0] lookup(input int k, input logic [AW-1:0] src);
    logic [PW-1:0] res;
    res = map_q[src];
    for (int j = 0; j < RenameWidth; j++) begin
      if ((j < k) && valid_i[j] && (rd_i[j*AW +: AW] == src) && rd_renamed(src)) begin
        res = phys_rd_i[j*PW +: PW];
      end else begin
        res = res;
      end
    end
    if (X0Hard && (src == {AW{1'b0}})) begin
      res = {PW{1'b0}};
    end else begin
      res = res;
    end
    return res;
  endfunction

  assign ready_o     = (state == StRun);
  assign ckpt_id_o   = tail;
  assign ckpt_full_o = full;

  // FSM next state: walk every table entry once, then run forever.
  always_comb begin
    state_next = state;
    case (state)
      StInit: begin
        if (init_cnt == AW'(NumArchRegs - 1)) state_next = StRun;
        else                                  state_next = StInit;
      end
      StRun:   state_next = StRun;
      default: state_next = StInit;
    endcase
  end

  // Combinational rename lookups for every slot.
  always_comb begin
    phys_rs1_o = '0;
    phys_rs2_o = '0;
    old_rd_o   = '0;
    for (int k = 0; k < RenameWidth; k++) begin
      phys_rs1_o[k*PW +: PW] = lookup(k, rs1_i[k*AW +: AW]);
      phys_rs2_o[k*PW +: PW] = lookup(k, rs2_i[k*AW +: AW]);
      old_rd_o[k*PW +: PW]   = lookup(k, rd_i[k*AW +: AW]);
    end
  end

  // Checkpoint pointer control; a free in the same cycle is applied before restore liveness is judged.
  always_comb begin
    free_ok     = free_i & ready_o & (count != {(CW+1){1'b0}});
    head_f      = head + CW'(free_ok);
    count_f     = count - (CW+1)'(free_ok);
    restore_off = restore_id_i - head_f;
    restore_ok  = restore_i & ready_o & ({1'b0, restore_off} < count_f);
    rename_en   = ready_o & ~restore_i;
    // A same-cycle free makes room for the new checkpoint even when full.
    ckpt_gnt_o  = ckpt_req_i & ready_o & ~restore_i & (~full | free_ok);
    head_n      = head_f;
    tail_n      = tail;
    count_n     = count_f;
    if (restore_ok) begin
      tail_n  = restore_id_i + CW'(1'b1);
      count_n = {1'b0, restore_off} + (CW+1)'(1'b1);
    end else if (ckpt_gnt_o) begin
      tail_n  = tail + CW'(1'b1);
      count_n = count_f + (CW+1)'(1'b1);
    end else begin
      tail_n  = tail;
      count_n = count_f;
    end
  end

  // Next map contents: identity fill, checkpoint restore, or in-order rename writes.
  always_comb begin
    map_d = map_q;
    if (state == StInit) begin
      map_d[init_cnt] = PW'(init_cnt);
    end else if (restore_ok) begin
      map_d = ckpt_q[restore_id_i];
    end else if (rename_en) begin
      for (int k = 0; k < RenameWidth; k++) begin
        if (valid_i[k] && rd_renamed(rd_i[k*AW +: AW])) begin
          map_d[rd_i[k*AW +: AW]] = phys_rd_i[k*PW +: PW];
        end else begin
          map_d = map_d;
        end
      end
    end else begin
      map_d = map_q;
    end
  end

  // Control state, pointers and full flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= StInit;
      init_cnt <= {AW{1'b0}};
      head     <= {CW{1'b0}};
      tail     <= {CW{1'b0}};
      count    <= {(CW+1){1'b0}};
      full     <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= (state == StInit) ? init_cnt + AW'(1'b1) : init_cnt;
      head     <= head_n;
      tail     <= tail_n;
      count    <= count_n;
      full     <= (count_n == (CW+1)'(NumCkpts));
    end
  end

  // Map storage; contents are rebuilt by the init walk after reset.
  always_ff @(posedge clk_i) begin
    map_q <= map_d;
  end

  // Snapshot the post-rename map into the tail slot on a granted checkpoint.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ckpt_gnt_o) begin
      ckpt_q[tail] <= map_d;
    end
  end

endmodule

// File: tb/tb_rename_map_table_ckpt.sv
// Directed bench for rename_map_table_ckpt with hand-computed expectations.
module tb_rename_map_table_ckpt;
  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [1:0]  valid;
  logic [9:0]  rs1, rs2, rd;
  logic [11:0] prd;
  logic [11:0] prs1, prs2, old_rd;
  logic        ckpt_req, ckpt_gnt, ckpt_full, free, restore;
  logic [1:0]  ckpt_id, restore_id;
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  rename_map_table_ckpt dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready),
    .valid_i(valid), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .phys_rd_i(prd),
    .phys_rs1_o(prs1), .phys_rs2_o(prs2), .old_rd_o(old_rd),
    .ckpt_req_i(ckpt_req), .ckpt_gnt_o(ckpt_gnt), .ckpt_id_o(ckpt_id),
    .ckpt_full_o(ckpt_full), .free_i(free), .restore_i(restore),
    .restore_id_i(restore_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    valid = 2'b00; rs1 = '0; rs2 = '0; rd = '0; prd = '0;
    ckpt_req = 1'b0; free = 1'b0; restore = 1'b0; restore_id = 2'd0;
  endtask

  // Advance one clock and land just after the falling edge with inputs cleared.
  task automatic next();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rs1[4:0] = 5'd5;
    #1;
    chk("rst_full", ckpt_full, 0);
    chk("rst_id", ckpt_id, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("init_ready_%0d", i), ready, 0);
      @(negedge clk);
      #1;
    end
    chk("ready_up", ready, 1);
    chk("init_x5", prs1[5:0], 5);

    // Intra-group forwarding.
    next();
    valid = 2'b11;
    rs1 = {5'd3, 5'd3}; rs2 = {5'd7, 5'd0}; rd = {5'd3, 5'd3}; prd = {6'd41, 6'd40};
    #1;
    chk("fwd_s0_rs1", prs1[5:0], 3);
    chk("fwd_s1_rs1", prs1[11:6], 40);
    chk("fwd_s1_rs2", prs2[11:6], 7);
    chk("fwd_s0_old", old_rd[5:0], 3);
    chk("fwd_s1_old", old_rd[11:6], 40);
    next();
    rs1[4:0] = 5'd3;
    #1;
    chk("wr_hi_wins", prs1[5:0], 41);

    // Rename + checkpoint, rename, restore.
    next();
    valid = 2'b01; rd[4:0] = 5'd7; prd[5:0] = 6'd50; ckpt_req = 1'b1;
    #1;
    chk("ck0_gnt", ckpt_gnt, 1);
    chk("ck0_id", ckpt_id, 0);
    next();
    valid = 2'b01; rd[4:0] = 5'd7; prd[5:0] = 6'd51;
    next();
    rs1[4:0] = 5'd7;
    #1;
    chk("x7_51", prs1[5:0], 51);
    valid = 2'b01; rd[4:0] = 5'd7; prd[5:0] = 6'd55; ckpt_req = 1'b1;
    restore = 1'b1; restore_id = 2'd0;
    #1;
    chk("rst_blocks_gnt", ckpt_gnt, 0);
    next();
    rs1[4:0] = 5'd7; rs2[4:0] = 5'd3;
    #1;
    chk("restored_x7", prs1[5:0], 50);
    chk("restored_x3", prs2[5:0], 41);
    chk("restored_tail", ckpt_id, 1);
    chk("restored_nfull", ckpt_full, 0);

    // Fill checkpoints, request while full, then free+checkpoint.
    for (int i = 1; i < 4; i++) begin
      next();
      ckpt_req = 1'b1;
      #1;
      chk($sformatf("fill_gnt_%0d", i), ckpt_gnt, 1);
      chk($sformatf("fill_id_%0d", i), ckpt_id, i);
    end
    next();
    #1;
    chk("full_set", ckpt_full, 1);
    ckpt_req = 1'b1; valid = 2'b01; rd[4:0] = 5'd9; prd[5:0] = 6'd33;
    #1;
    chk("full_no_gnt", ckpt_gnt, 0);
    next();
    rs1[4:0] = 5'd9;
    #1;
    chk("full_rename", prs1[5:0], 33);
    free = 1'b1; ckpt_req = 1'b1;
    #1;
    chk("free_ck_gnt", ckpt_gnt, 1);
    chk("free_ck_id", ckpt_id, 0);
    next();
    #1;
    chk("free_ck_full", ckpt_full, 1);
    chk("free_ck_tail", ckpt_id, 1);

    // Mid-operation reset restarts the init walk.
    rst = 1'b1;
    next();
    rst = 1'b0;
    #1;
    chk("rst2_ready", ready, 0);
    chk("rst2_full", ckpt_full, 0);
    chk("rst2_id", ckpt_id, 0);
    for (int i = 0; i < 64 && !ready; i++) @(negedge clk);
    #1;
    chk("rst2_ready_up", ready, 1);
    rs1[4:0] = 5'd7;
    #1;
    chk("rst2_x7", prs1[5:0], 7);

    // Free on empty, three checkpoints, restore id 1, restore non-live id 3.
    next();
    free = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next();
      valid = 2'b01; rd[4:0] = 5'd1; prd[5:0] = 6'(10 + i); ckpt_req = 1'b1;
      #1;
      chk($sformatf("r_id_%0d", i), ckpt_id, i);
    end
    next();
    restore = 1'b1; restore_id = 2'd1;
    next();
    rs1[4:0] = 5'd1;
    #1;
    chk("r1_x1", prs1[5:0], 11);
    chk("r1_tail", ckpt_id, 2);
    restore = 1'b1; restore_id = 2'd3;
    next();
    rs1[4:0] = 5'd1;
    #1;
    chk("r3_x1", prs1[5:0], 11);
    chk("r3_tail", ckpt_id, 2);
    ckpt_req = 1'b1;
    next();
    #1;
    chk("cnt3_nfull", ckpt_full, 0);
    ckpt_req = 1'b1;
    next();
    #1;
    chk("cnt4_full", ckpt_full, 1);

    // Free the very slot being restored: restore is ignored.
    free = 1'b1; restore = 1'b1; restore_id = 2'd0;
    next();
    rs1[4:0] = 5'd1;
    #1;
    chk("fr_nfull", ckpt_full, 0);
    chk("fr_tail", ckpt_id, 0);
    chk("fr_x1", prs1[5:0], 11);

`ifdef MAP_TABLE_X0_HARDWIRED_EN
    next();
    valid = 2'b01; rd[4:0] = 5'd0; prd[5:0] = 6'd60; rs1[9:5] = 5'd0;
    #1;
    chk("x0_nofwd", prs1[11:6], 0);
    chk("x0_old", old_rd[5:0], 0);
    next();
    rs1[4:0] = 5'd0;
    #1;
    chk("x0_read", prs1[5:0], 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
